// File: rtl/fifo_serial_drain.sv
// Pops words from a synchronous FIFO and sends each one as a start bit, WIDTH data bits
// (LSB first) and a stop bit. A new pop happens only once the previous frame has finished.
`timescale 1ns/1ps
module fifo_serial_drain #(
  parameter int WIDTH      = 16,
  parameter int BIT_CYCLES = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_re,
  output logic             ser_out,
  output logic             busy,
  output logic             frame_done,
  output logic [15:0]      word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam int             BIT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [7:0]     CYC_LAST  = 8'(BIT_CYCLES - 1);
  localparam logic [7:0]     CYC_PRE   = 8'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [1:0]     LAT_INIT  = 2'(RD_LATENCY);

  logic [2:0]       state_q, state_d;
  logic [7:0]       cyc_q, cyc_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [1:0]       lat_q, lat_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             fifo_re_q, fifo_re_d;
  logic             ser_q, ser_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      word_count_q, word_count_d;
  logic             cyc_end;

  assign cyc_end = (cyc_q == CYC_LAST);

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_idx_d    = bit_idx_q;
    lat_d        = lat_q;
    shift_d      = shift_q;
    fifo_re_d    = 1'b0;
    ser_d        = ser_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    word_count_d = word_count_q;
    // Outputs are registered, so each one is set on the transition into the cycle it belongs to.
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) begin
          state_d   = S_READ;
          fifo_re_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        lat_d   = LAT_INIT;
      end
      S_WAIT: begin
        if (lat_q == 2'd1) begin
          shift_d = fifo_dout;
          state_d = S_START;
          ser_d   = 1'b0;
          cyc_d   = 8'd0;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      S_START: begin
        if (cyc_end) begin
          cyc_d     = 8'd0;
          state_d   = S_DATA;
          bit_idx_d = '0;
          ser_d     = shift_q[0];
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      S_DATA: begin
        if (cyc_end) begin
          cyc_d = 8'd0;
          if (bit_idx_q == BIT_LAST) begin
            state_d = S_STOP;
            ser_d   = 1'b1;
            // A one-cycle stop bit means its only cycle is also the last one.
            if (BIT_CYCLES == 1) done_d = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            shift_d   = shift_q >> 1;
            ser_d     = shift_q[1];
          end
        end else begin
          cyc_d = cyc_q + 8'd1;
        end
      end
      S_STOP: begin
        if (cyc_end) begin
          cyc_d        = 8'd0;
          state_d      = S_IDLE;
          busy_d       = 1'b0;
          word_count_d = word_count_q + 16'd1;
        end else begin
          cyc_d = cyc_q + 8'd1;
          if (cyc_q == CYC_PRE) done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cyc_q        <= 8'd0;
      bit_idx_q    <= '0;
      lat_q        <= 2'd0;
      shift_q      <= '0;
      fifo_re_q    <= 1'b0;
      ser_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_idx_q    <= bit_idx_d;
      lat_q        <= lat_d;
      shift_q      <= shift_d;
      fifo_re_q    <= fifo_re_d;
      ser_q        <= ser_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
    end
  end

  assign fifo_re    = fifo_re_q;
  assign ser_out    = ser_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign word_count = word_count_q;

endmodule

// File: doc/fifo_serial_drain.md
Name: fifo_serial_drain

Overview:
- Downstream consumer of the 16-bit synchronous FIFO.
- Pops one word at a time using the FIFO's read strobe and empty flag, then shifts the word out on a single-wire framed serial line: start bit, WIDTH data bits LSB-first, stop bit.
- Provides the read-side pacing the FIFO needs. The FIFO is only read when a word can be fully transmitted.

Parameters:
- WIDTH, 16: data word width; matches the FIFO data width.
- BIT_CYCLES, 4: clocks per serial bit; legal range 1..255.
- RD_LATENCY, 1: clocks from the FIFO sampling re to its data_out holding the popped word; legal range 1..3.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- enable  input  1  permits starting new frames; does not abort a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  WIDTH  FIFO read data.
- fifo_re  output  1  FIFO read strobe, one-cycle pulse per word.
- ser_out  output  1  serial line; idles high.
- busy  output  1  high from the fifo_re cycle through the last stop-bit cycle.
- frame_done  output  1  one-cycle pulse in the last stop-bit cycle.
- word_count  output  16  frames completed; wraps 0xFFFF to 0x0000.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, fifo_re=0, ser_out=1, busy=0, frame_done=0, word_count=0.
  - Shift register, bit counter and cycle counter are cleared.
- Registers: all outputs are registered.
- States: IDLE, READ, WAIT, START, DATA, STOP.
- IDLE:
  - ser_out=1, busy=0.
  - If enable=1 and fifo_empty=0, go to READ.
  - Otherwise stay in IDLE.
- READ:
  - fifo_re=1 for exactly this cycle, busy=1.
  - Go to WAIT and load the latency counter with RD_LATENCY.
- WAIT:
  - Count RD_LATENCY cycles.
  - On the final cycle, capture fifo_dout into the shift register and go to START.
- START: ser_out=0 for BIT_CYCLES cycles, then go to DATA with bit index 0.
- DATA:
  - ser_out=shift[0] for BIT_CYCLES cycles per bit, then shift right.
  - After WIDTH bits, go to STOP.
- STOP:
  - ser_out=1 for BIT_CYCLES cycles.
  - On the last cycle: frame_done=1, word_count+1, then go to IDLE.
- Timing:
  - START begins RD_LATENCY+1 cycles after the fifo_re cycle.
  - Frame length is (WIDTH+2)*BIT_CYCLES cycles, which is 72 at the defaults.
  - Minimum spacing between consecutive fifo_re pulses is (WIDTH+2)*BIT_CYCLES + RD_LATENCY + 2 cycles, which is 75 at the defaults.
- fifo_re is never asserted while fifo_empty=1 is sampled in IDLE.
- fifo_re is never asserted outside the READ state.
- enable:
  - Sampled only in IDLE.
  - Dropping enable mid-frame lets the current frame finish, including frame_done; the block then stays in IDLE.
- fifo_empty rising mid-frame has no effect on the current frame.
- Reset mid-frame:
  - ser_out returns high immediately (asynchronously).
  - The popped word is discarded and not retransmitted.
  - frame_done is not pulsed and word_count is cleared.
- BIT_CYCLES=1: every state except READ/WAIT holds exactly one cycle per bit; the cycle counter never wraps incorrectly.
- word_count at 0xFFFF plus one completed frame gives 0x0000, with no flag.

Test Plan:
- Single word: FIFO holds 16'h0001, enable=1, defaults.
  - One fifo_re pulse.
  - ser_out: 0 for 4 cycles, 1 for 4, 0 for 60, 1 for 4.
  - One frame_done; word_count=1; busy low afterwards.
- Empty FIFO: enable=1 with fifo_empty=1 for 200 cycles → fifo_re never high, ser_out stays 1, busy stays 0.
- Back-to-back from a real FIFO: write 1..8, enable=1.
  - Eight frames decode to 1..8 in order.
  - fifo_re pulses exactly 8 times, spaced 75 cycles apart.
  - fifo_empty is high after the 8th read; word_count=8.
- Enable dropped mid-frame: FIFO holds 16'hA5A5 and 16'h5A5A; deassert enable during the DATA state of the first frame.
  - The first frame completes bit-exact with frame_done.
  - No second fifo_re.
  - Re-asserting enable sends 16'h5A5A.
- Reset mid-frame: assert rst=0 during DATA of 16'hFFFF.
  - Same cycle: ser_out=1, busy=0, word_count=0.
  - After release, the next FIFO word is sent intact.
- Parameter corners:
  - BIT_CYCLES=1, RD_LATENCY=3, word 16'h8001: frame is 18 cycles long and START begins 4 cycles after fifo_re.
  - Force word_count to 0xFFFF and complete one frame: word_count becomes 0x0000.
